dmrf_o: RTL and testbench
=========================

# dmrf_o

Double-buffered output register file for the TAPU array, the store-side counterpart of the load buffer. The execution side writes one 256-bit result row per cycle into a selected tile at an explicit address. The store side, on a start command, reads a selected tile from row 0 to a programmed last row. It streams the rows out as an AXI-Stream master with full backpressure support, `tlast` on the final beat and a done pulse. While one tile drains to the store DMA, the TAPUs fill the other.

## Interface
- `AXIS_STORE_DATA_WIDTH`, default 256: width of the output stream data.
- `BRAM_DATA_WIDTH`, default 256: row width; must equal `AXIS_STORE_DATA_WIDTH`.
- `EXEC_ADDR_WIDTH`, default 9: row address width per tile.
- `STORE_ADDR_WIDTH`, default 9: store depth width; must equal `EXEC_ADDR_WIDTH`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `dmrfo_exec_wr_en`  in  1  write strobe from TAPU result path.
- `dmrfo_exec_tile_sel`  in  1  tile written by exec.
- `dmrfo_exec_addr`  in  `EXEC_ADDR_WIDTH`  row written by exec.
- `dmrfo_exec_data`  in  `BRAM_DATA_WIDTH`  row data.
- `dmrfo_store_start`  in  1  single-cycle start pulse.
- `dmrfo_store_tile_sel`  in  1  tile to drain; sampled on an accepted start.
- `dmrfo_store_depth`  in  `STORE_ADDR_WIDTH`  index of the last row to send; sampled on an accepted start.
- `dmrfo_store_busy`  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- `dmrfo_store_done`  out  1  single-cycle pulse, equal to the handshake of the `tlast` beat.
- `m_axis_dmrfo_store_tdata`  out  `AXIS_STORE_DATA_WIDTH`  row data.
- `m_axis_dmrfo_store_tvalid`  out  1  AXIS valid.
- `m_axis_dmrfo_store_tready`  in  1  AXIS ready.
- `m_axis_dmrfo_store_tkeep`  out  `AXIS_STORE_DATA_WIDTH/8`  always all ones.
- `m_axis_dmrfo_store_tlast`  out  1  marks the row at index `depth`.

## Operation
**Memory**
- Organisation is 2 × 2^`EXEC_ADDR_WIDTH` rows; the row address is `{tile_sel, addr}`.
- Simple dual port: exec write port and store read port, with a registered read (1-cycle latency).
- A read of the row written in the same cycle returns the old data.
- No hazard protection. Software must not write the tile currently being stored; the result of doing so is undefined but must not hang the FSM.

**FSM: IDLE, STREAM, DRAIN**
- IDLE: `dmrfo_store_start` is accepted only in IDLE. On acceptance, latch the tile and depth, clear the read pointer, and go to STREAM.
- STREAM: issue a read at pointer `rd_ptr` when there is space (rule below), then increment. After issuing the read at `rd_ptr == depth`, go to DRAIN.
- DRAIN: wait until the output buffer is empty and no read is in flight, then go to IDLE.
- A start pulse in STREAM or DRAIN is ignored; no queuing.

**Output buffer**
- 2-entry FIFO driving the AXIS outputs directly; `tvalid` means the FIFO is non-empty.
- `inflight` is 1 while a read issued last cycle has not yet landed.
- Issue rule: `occ + inflight - pop < 2`, where `pop = tvalid & tready`. This sustains 1 beat/cycle with `tready` held high and never overflows under any `tready` pattern.
- Each FIFO entry carries its own `last` flag, set on the entry read from row `depth`.
- The beat count is `depth + 1`. `depth = 0` sends exactly one beat, with `tlast` set.

**Reset**
- Reset is asynchronous and may arrive mid-stream. It forces IDLE, empties the FIFO, clears `inflight` and `rd_ptr`, and deasserts `tvalid` immediately.
- Memory contents are not cleared.

## Timing
- Reset values: `tvalid`, `tlast`, `busy` and `done` are 0; `tdata` is 0; `tkeep` is all ones.
- A start accepted at cycle 0 gives: `busy` high at 1, first read at 1, first `tvalid` at 2.
- With `tready` held at 1, beat k is transferred at cycle 2+k and the last beat at cycle 2+depth.
- `done` equals `tvalid & tready & tlast`, combinational, in the last-beat cycle.
- `busy` falls in the cycle after the last handshake. A new start is accepted from that cycle on.
- `tdata`, `tlast` and `tvalid` stay stable while `tvalid & ~tready` (AXIS rule).
- Exec write latency is 1: a row written at cycle n is readable by a store read issued at n+1 or later.

## Test plan
- **Basic drain:** exec writes rows 0..3 of tile 0 with values 0xA0..0xA3; start with tile 0, depth 3, `tready` = 1 → beats 0xA0..0xA3 at cycles 2..5, `tlast` and `done` at cycle 5, `busy` low at cycle 6.
- **Backpressure:** depth 15 with `tready` random at 50% → 16 beats in order with no loss or duplication, data held stable while stalled, exactly one `done`.
- **Single row:** depth 0 → exactly one beat, carrying both `tlast` and `done`.
- **Double buffer:** store tile 0 (depth 127) while exec writes all 128 rows of tile 1; then store tile 1 → both streams match their expected data exactly.
- **Start while busy:** a second start during STREAM with tile 1 and depth 5 is ignored; the original stream completes unchanged and `done` pulses once.
- **Reset mid-stream:** assert `rst` at beat 10 of 32 → `tvalid` and `busy` drop immediately. After release, a new start with depth 2 sends 3 correct beats.

Source files
------------

// File: rtl/dmrf_o_if.sv
// Bus bundle for the double-buffered output register file: exec write port,
// store command/status and the AXI-Stream store master.
interface dmrf_o_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9
);
  logic                      dmrfo_exec_wr_en;
  logic                      dmrfo_exec_tile_sel;
  logic [ADDR_WIDTH-1:0]     dmrfo_exec_addr;
  logic [DATA_WIDTH-1:0]     dmrfo_exec_data;

  logic                      dmrfo_store_start;
  logic                      dmrfo_store_tile_sel;
  logic [ADDR_WIDTH-1:0]     dmrfo_store_depth;
  logic                      dmrfo_store_busy;
  logic                      dmrfo_store_done;

  logic [DATA_WIDTH-1:0]     m_axis_dmrfo_store_tdata;
  logic                      m_axis_dmrfo_store_tvalid;
  logic                      m_axis_dmrfo_store_tready;
  logic [DATA_WIDTH/8-1:0]   m_axis_dmrfo_store_tkeep;
  logic                      m_axis_dmrfo_store_tlast;

  // Register-file side: consumes exec writes and store commands, drives the stream
  modport master (
    input  dmrfo_exec_wr_en, dmrfo_exec_tile_sel, dmrfo_exec_addr, dmrfo_exec_data,
    input  dmrfo_store_start, dmrfo_store_tile_sel, dmrfo_store_depth,
    output dmrfo_store_busy, dmrfo_store_done,
    output m_axis_dmrfo_store_tdata, m_axis_dmrfo_store_tvalid,
    input  m_axis_dmrfo_store_tready,
    output m_axis_dmrfo_store_tkeep, m_axis_dmrfo_store_tlast
  );

  // Environment side: TAPU result path, store controller and stream sink
  modport slave (
    output dmrfo_exec_wr_en, dmrfo_exec_tile_sel, dmrfo_exec_addr, dmrfo_exec_data,
    output dmrfo_store_start, dmrfo_store_tile_sel, dmrfo_store_depth,
    input  dmrfo_store_busy, dmrfo_store_done,
    input  m_axis_dmrfo_store_tdata, m_axis_dmrfo_store_tvalid,
    output m_axis_dmrfo_store_tready,
    input  m_axis_dmrfo_store_tkeep, m_axis_dmrfo_store_tlast
  );
endinterface

// File: rtl/dmrf_o.sv
// Double-buffered output register file. TAPUs write result rows into one tile
// while the other tile is drained as an AXI-Stream to the store DMA.
// The 2-entry output buffer is the registered memory read stage (the row in
// flight) plus a small skid FIFO; the head of the buffer is the FIFO head when
// the FIFO holds data, otherwise the freshly landed read.
module dmrf_o #(
  parameter int AXIS_STORE_DATA_WIDTH = 256,
  parameter int BRAM_DATA_WIDTH       = 256,
  parameter int EXEC_ADDR_WIDTH       = 9,
  parameter int STORE_ADDR_WIDTH      = 9
) (
  input logic       clk,
  input logic       rst,
  dmrf_o_if.master  bus
);

  localparam int ROWS   = 2 ** (EXEC_ADDR_WIDTH + 1);
  localparam int KEEP_W = AXIS_STORE_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t state_q, state_d;

  logic [BRAM_DATA_WIDTH-1:0]       mem [ROWS];
  logic [BRAM_DATA_WIDTH-1:0]       rd_data_q;
  logic                             inflight_q;
  logic                             inflight_last_q;

  logic                             tile_q;
  logic [STORE_ADDR_WIDTH-1:0]      depth_q;
  logic [EXEC_ADDR_WIDTH-1:0]       rd_ptr;

  logic [AXIS_STORE_DATA_WIDTH-1:0] fifo_data [2];
  logic                             fifo_last [2];
  logic                             fifo_head;
  logic                             fifo_tail;
  logic [1:0]                       fifo_occ;

  logic                             start_ok;
  logic                             busy;
  logic                             issue;
  logic                             issue_last;
  logic [2:0]                       fill_level;
  logic [2:0]                       fill_limit;

  logic                             tvalid;
  logic                             tlast;
  logic [AXIS_STORE_DATA_WIDTH-1:0] tdata;
  logic                             pop;
  logic                             done;
  logic                             fifo_push;
  logic                             fifo_pop;

  assign start_ok = (state_q == IDLE) && bus.dmrfo_store_start;

  // Buffer head: FIFO entry if any, else the read that landed this cycle
  assign tvalid = (fifo_occ != 2'd0) || inflight_q;
  assign tdata  = (fifo_occ != 2'd0) ? fifo_data[fifo_head] :
                  (inflight_q ? rd_data_q : '0);
  assign tlast  = (fifo_occ != 2'd0) ? fifo_last[fifo_head] :
                  (inflight_q & inflight_last_q);
  assign pop    = tvalid & bus.m_axis_dmrfo_store_tready;
  assign done   = pop & tlast;

  // A landed read bypasses the FIFO only when it is consumed straight away
  assign fifo_push = inflight_q && !(pop && (fifo_occ == 2'd0));
  assign fifo_pop  = pop && (fifo_occ != 2'd0);

  assign bus.m_axis_dmrfo_store_tdata  = tdata;
  assign bus.m_axis_dmrfo_store_tvalid = tvalid;
  assign bus.m_axis_dmrfo_store_tlast  = tlast;
  assign bus.m_axis_dmrfo_store_tkeep  = {KEEP_W{1'b1}};
  assign bus.dmrfo_store_done          = done;
  assign bus.dmrfo_store_busy          = busy;

  // Exec write port; memory contents survive reset
  always_ff @(posedge clk) begin
    if (bus.dmrfo_exec_wr_en)
      mem[{bus.dmrfo_exec_tile_sel, bus.dmrfo_exec_addr}] <= bus.dmrfo_exec_data;
  end

  // Registered store read port; a same-cycle write to this row returns old data
  always_ff @(posedge clk) begin
    if (issue)
      rd_data_q <= mem[{tile_q, rd_ptr}];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: stream until the last row is issued, then drain the buffer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = STREAM;
      STREAM:  if (issue_last) state_d = DRAIN;
      DRAIN:   if (done || ((fifo_occ == 2'd0) && !inflight_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and read issue whenever the buffer has room
  always_comb begin
    busy       = (state_q != IDLE);
    fill_level = {1'b0, fifo_occ} + {2'b00, inflight_q};
    fill_limit = 3'd2 + {2'b00, pop};
    issue      = (state_q == STREAM) && (fill_level < fill_limit);
    issue_last = issue && (rd_ptr == depth_q);
  end

  // Command latch and read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_q  <= 1'b0;
      depth_q <= '0;
      rd_ptr  <= '0;
    end else if (start_ok) begin
      tile_q  <= bus.dmrfo_store_tile_sel;
      depth_q <= bus.dmrfo_store_depth;
      rd_ptr  <= '0;
    end else if (issue) begin
      rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  // In-flight read tracking, with the last-row marker travelling alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  // Skid FIFO holding landed rows that the sink has not yet taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      fifo_head    <= 1'b0;
      fifo_tail    <= 1'b0;
      fifo_occ     <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_data[fifo_tail] <= rd_data_q;
        fifo_last[fifo_tail] <= inflight_last_q;
        fifo_tail            <= ~fifo_tail;
      end
      if (fifo_pop)
        fifo_head <= ~fifo_head;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_occ <= fifo_occ + 2'd1;
        2'b01:   fifo_occ <= fifo_occ - 2'd1;
        default: fifo_occ <= fifo_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmrf_o.sv
// Testbench for dmrf_o: a shadow copy of both tiles predicts every stream.
module tb_dmrf_o;
  localparam int DW = 256;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   start_cyc = 0;

  logic [DW-1:0] shadow [2][1 << AW];
  logic [DW-1:0] got_data [$];
  bit            got_last [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmrf_o_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmrf_o #(
    .AXIS_STORE_DATA_WIDTH(DW),
    .BRAM_DATA_WIDTH(DW),
    .EXEC_ADDR_WIDTH(AW),
    .STORE_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One exec write per call; the shadow memory follows every write
  task automatic exec_write(input bit tile, input int addr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus.dmrfo_exec_wr_en    = 1'b1;
    bus.dmrfo_exec_tile_sel = tile;
    bus.dmrfo_exec_addr     = addr[AW-1:0];
    bus.dmrfo_exec_data     = d;
    shadow[tile][addr]      = d;
  endtask

  task automatic exec_idle();
    @(posedge clk); #1;
    bus.dmrfo_exec_wr_en = 1'b0;
  endtask

  // Start pulse; the cycle it is high is relative cycle 0
  task automatic start_store(input bit tile, input int depth);
    @(posedge clk); #1;
    bus.dmrfo_store_start    = 1'b1;
    bus.dmrfo_store_tile_sel = tile;
    bus.dmrfo_store_depth    = depth[AW-1:0];
    start_cyc                = cyc;
  endtask

  // Sink: randomized tready, records handshaken beats and protocol events
  task automatic collect(input int ready_pct, input int second_rel, input int budget,
                         output int n_done, output int n_bad_done, output int n_unstable,
                         output bit timed_out, output int first_rel, output int done_rel,
                         output int fall_rel, output bit busy_at1);
    logic [DW-1:0] prev_data;
    bit prev_last, prev_stall, v, r, l, finished;
    int rel;
    got_data.delete();
    got_last.delete();
    n_done = 0; n_bad_done = 0; n_unstable = 0; timed_out = 1'b0;
    first_rel = -1; done_rel = -1; fall_rel = -1; busy_at1 = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; finished = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      rel = cyc - start_cyc;
      if (rel == second_rel) begin
        bus.dmrfo_store_start    = 1'b1;
        bus.dmrfo_store_tile_sel = 1'b1;
        bus.dmrfo_store_depth    = 9'd5;
      end else begin
        bus.dmrfo_store_start = 1'b0;
      end
      bus.m_axis_dmrfo_store_tready = ($urandom_range(0, 99) < ready_pct);
      #4;
      v = bus.m_axis_dmrfo_store_tvalid;
      r = bus.m_axis_dmrfo_store_tready;
      l = bus.m_axis_dmrfo_store_tlast;
      if (prev_stall && (!v || bus.m_axis_dmrfo_store_tdata !== prev_data || l !== prev_last))
        n_unstable++;
      if (bus.dmrfo_store_done !== (v & r & l)) n_bad_done++;
      if (bus.dmrfo_store_done === 1'b1) begin
        n_done++;
        done_rel = rel;
      end
      if (v && r) begin
        got_data.push_back(bus.m_axis_dmrfo_store_tdata);
        got_last.push_back(l);
        if (first_rel < 0) first_rel = rel;
      end
      prev_stall = v && !r;
      prev_data  = bus.m_axis_dmrfo_store_tdata;
      prev_last  = l;
      if (rel == 1) busy_at1 = bus.dmrfo_store_busy;
      if (rel >= 1 && bus.dmrfo_store_busy == 1'b0) begin
        fall_rel = rel;
        finished = 1'b1;
        break;
      end
    end
    timed_out = !finished;
    bus.dmrfo_store_start         = 1'b0;
    bus.m_axis_dmrfo_store_tready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.m_axis_dmrfo_store_tvalid !== 1'b0) begin n_fail++;
      $display("[TB] FAIL reset_tvalid: got %b expected 0", bus.m_axis_dmrfo_store_tvalid); end
    n_cmp++; if (bus.m_axis_dmrfo_store_tlast !== 1'b0) begin n_fail++;
      $display("[TB] FAIL reset_tlast: got %b expected 0", bus.m_axis_dmrfo_store_tlast); end
    n_cmp++; if (bus.dmrfo_store_busy !== 1'b0) begin n_fail++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.dmrfo_store_busy); end
    n_cmp++; if (bus.dmrfo_store_done !== 1'b0) begin n_fail++;
      $display("[TB] FAIL reset_done: got %b expected 0", bus.dmrfo_store_done); end
    n_cmp++; if (bus.m_axis_dmrfo_store_tdata !== {DW{1'b0}}) begin n_fail++;
      $display("[TB] FAIL reset_tdata: got %h expected 0", bus.m_axis_dmrfo_store_tdata); end
    n_cmp++; if (bus.m_axis_dmrfo_store_tkeep !== {(DW/8){1'b1}}) begin n_fail++;
      $display("[TB] FAIL reset_tkeep: got %h expected all ones", bus.m_axis_dmrfo_store_tkeep); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nd, nbd, nu, fr, dr, br; bit to, b1;
    logic [DW-1:0] exp_row;
    for (int i = 0; i < 4; i++) begin
      exp_row = DW'(32'hA0 + i);
      exec_write(1'b0, i, exp_row);
    end
    exec_idle();
    start_store(1'b0, 3);
    collect(100, -1, 100, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
    n_cmp++; if (got_data.size() !== 4) begin n_fail++;
      $display("[TB] FAIL basic_beats: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      exp_row = DW'(32'hA0 + i);
      n_cmp++; if (got_data[i] !== exp_row) begin n_fail++;
        $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], exp_row); end
      n_cmp++; if (got_last[i] !== (i == 3)) begin n_fail++;
        $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], i == 3); end
    end
    n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_c1: got %b expected 1", b1); end
    n_cmp++; if (fr !== 2) begin n_fail++; $display("[TB] FAIL basic_first_beat_cycle: got %0d expected 2", fr); end
    n_cmp++; if (dr !== 5) begin n_fail++; $display("[TB] FAIL basic_done_cycle: got %0d expected 5", dr); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL basic_done_count: got %0d expected 1", nd); end
    n_cmp++; if (br !== 6) begin n_fail++; $display("[TB] FAIL basic_busy_fall: got %0d expected 6", br); end
    n_cmp++; if (nbd !== 0) begin n_fail++; $display("[TB] FAIL basic_done_rule: got %0d expected 0", nbd); end
  endtask

  task automatic test_backpressure();
    int nd, nbd, nu, fr, dr, br; bit to, b1;
    for (int i = 0; i < 16; i++) exec_write(1'b1, i, rand_row());
    exec_idle();
    start_store(1'b1, 15);
    collect(50, -1, 1000, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_timeout: got %b expected 0", to); end
    n_cmp++; if (got_data.size() !== 16) begin n_fail++;
      $display("[TB] FAIL bp_beats: got %0d expected 16", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      n_cmp++; if (got_data[i] !== shadow[1][i]) begin n_fail++;
        $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], shadow[1][i]); end
      n_cmp++; if (got_last[i] !== (i == 15)) begin n_fail++;
        $display("[TB] FAIL bp_last[%0d]: got %b expected %b", i, got_last[i], i == 15); end
    end
    n_cmp++; if (nu !== 0) begin n_fail++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", nu); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL bp_done_count: got %0d expected 1", nd); end
    n_cmp++; if (nbd !== 0) begin n_fail++; $display("[TB] FAIL bp_done_rule: got %0d expected 0", nbd); end
  endtask

  task automatic test_single_row();
    int nd, nbd, nu, fr, dr, br; bit to, b1;
    exec_write(1'b0, 0, rand_row());
    exec_idle();
    start_store(1'b0, 0);
    collect(60, -1, 200, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (got_data.size() !== 1) begin n_fail++;
      $display("[TB] FAIL single_beats: got %0d expected 1 (timeout %b)", got_data.size(), to); end
    if (got_data.size() >= 1) begin
      n_cmp++; if (got_data[0] !== shadow[0][0]) begin n_fail++;
        $display("[TB] FAIL single_data: got %h expected %h", got_data[0], shadow[0][0]); end
      n_cmp++; if (got_last[0] !== 1'b1) begin n_fail++;
        $display("[TB] FAIL single_last: got %b expected 1", got_last[0]); end
    end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL single_done_count: got %0d expected 1", nd); end
    n_cmp++; if (nbd !== 0) begin n_fail++; $display("[TB] FAIL single_done_rule: got %0d expected 0", nbd); end
  endtask

  task automatic test_double_buffer();
    int nd, nbd, nu, fr, dr, br; bit to, b1;
    logic [DW-1:0] exp0 [$];
    for (int i = 0; i < 128; i++) exec_write(1'b0, i, rand_row());
    exec_idle();
    for (int i = 0; i < 128; i++) exp0.push_back(shadow[0][i]);
    start_store(1'b0, 127);
    fork
      collect(80, -1, 2000, nd, nbd, nu, to, fr, dr, br, b1);
      begin
        for (int i = 0; i < 128; i++) exec_write(1'b1, i, rand_row());
        exec_idle();
      end
    join
    n_cmp++; if (got_data.size() !== 128 || to !== 1'b0) begin n_fail++;
      $display("[TB] FAIL dbuf_t0_beats: got %0d timeout %b expected 128 timeout 0", got_data.size(), to); end
    for (int i = 0; i < got_data.size() && i < 128; i++) begin
      n_cmp++; if (got_data[i] !== exp0[i]) begin n_fail++;
        $display("[TB] FAIL dbuf_t0_data[%0d]: got %h expected %h", i, got_data[i], exp0[i]); end
    end
    start_store(1'b1, 127);
    collect(100, -1, 400, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (got_data.size() !== 128 || to !== 1'b0) begin n_fail++;
      $display("[TB] FAIL dbuf_t1_beats: got %0d timeout %b expected 128 timeout 0", got_data.size(), to); end
    for (int i = 0; i < got_data.size() && i < 128; i++) begin
      n_cmp++; if (got_data[i] !== shadow[1][i]) begin n_fail++;
        $display("[TB] FAIL dbuf_t1_data[%0d]: got %h expected %h", i, got_data[i], shadow[1][i]); end
    end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL dbuf_t1_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_start_while_busy();
    int nd, nbd, nu, fr, dr, br, extra; bit to, b1;
    for (int i = 0; i < 10; i++) exec_write(1'b0, i, rand_row());
    for (int i = 0; i < 6; i++) exec_write(1'b1, i, rand_row());
    exec_idle();
    start_store(1'b0, 9);
    collect(100, 4, 200, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (got_data.size() !== 10 || to !== 1'b0) begin n_fail++;
      $display("[TB] FAIL swb_beats: got %0d timeout %b expected 10 timeout 0", got_data.size(), to); end
    for (int i = 0; i < got_data.size() && i < 10; i++) begin
      n_cmp++; if (got_data[i] !== shadow[0][i] || got_last[i] !== (i == 9)) begin n_fail++;
        $display("[TB] FAIL swb_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i],
                 shadow[0][i], i == 9); end
    end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL swb_done_count: got %0d expected 1", nd); end
    n_cmp++; if (br !== 12) begin n_fail++; $display("[TB] FAIL swb_busy_fall: got %0d expected 12", br); end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.m_axis_dmrfo_store_tready = 1'b1;
      #4;
      if (bus.m_axis_dmrfo_store_tvalid !== 1'b0 || bus.dmrfo_store_busy !== 1'b0) extra++;
    end
    bus.m_axis_dmrfo_store_tready = 1'b0;
    n_cmp++; if (extra !== 0) begin n_fail++;
      $display("[TB] FAIL swb_no_queued_start: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int nd, nbd, nu, fr, dr, br; bit to, b1, reached;
    for (int i = 0; i < 32; i++) exec_write(1'b0, i, rand_row());
    exec_idle();
    start_store(1'b0, 31);
    got_data.delete();
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      bus.dmrfo_store_start         = 1'b0;
      bus.m_axis_dmrfo_store_tready = 1'b1;
      #4;
      if (bus.m_axis_dmrfo_store_tvalid && bus.m_axis_dmrfo_store_tready)
        got_data.push_back(bus.m_axis_dmrfo_store_tdata);
      if (got_data.size() == 10) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_reach10: got %b expected 1", reached); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== shadow[0][i]) begin n_fail++;
        $display("[TB] FAIL rstmid_pre_data[%0d]: got %h expected %h", i, got_data[i], shadow[0][i]); end
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.m_axis_dmrfo_store_tvalid !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rstmid_tvalid: got %b expected 0", bus.m_axis_dmrfo_store_tvalid); end
    n_cmp++; if (bus.dmrfo_store_busy !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.dmrfo_store_busy); end
    bus.m_axis_dmrfo_store_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_store(1'b0, 2);
    collect(100, -1, 100, nd, nbd, nu, to, fr, dr, br, b1);
    n_cmp++; if (got_data.size() !== 3 || to !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rstmid_post_beats: got %0d timeout %b expected 3 timeout 0", got_data.size(), to); end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      n_cmp++; if (got_data[i] !== shadow[0][i] || got_last[i] !== (i == 2)) begin n_fail++;
        $display("[TB] FAIL rstmid_post_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i],
                 shadow[0][i], i == 2); end
    end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("[TB] FAIL rstmid_post_done: got %0d expected 1", nd); end
  endtask

  initial begin
    rst                           = 1'b1;
    bus.dmrfo_exec_wr_en          = 1'b0;
    bus.dmrfo_exec_tile_sel       = 1'b0;
    bus.dmrfo_exec_addr           = '0;
    bus.dmrfo_exec_data           = '0;
    bus.dmrfo_store_start         = 1'b0;
    bus.dmrfo_store_tile_sel      = 1'b0;
    bus.dmrfo_store_depth         = '0;
    bus.m_axis_dmrfo_store_tready = 1'b0;
    $display("[TB] dmrf_o test start");
    test_reset();
    test_basic();
    test_backpressure();
    test_single_row();
    test_double_buffer();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
